// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Two's-complement most-negative value for a given width, right-aligned.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int unsigned width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, flush, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// Outputs show the result of the step in progress, so the final bit is available in the done cycle.
module muldiv_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_c_o,
  output logic [WIDTH-1:0] quot_c_o,
  output logic [WIDTH-1:0] rem_c_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [WIDTH:0]   partial_c, diff_c;
  logic             ge_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    partial_c = {rem_q, quo_q[WIDTH-1]};
    diff_c    = partial_c - {1'b0, dsr_q};
    ge_c      = ~diff_c[WIDTH];
    rem_c_o   = ge_c ? diff_c[WIDTH-1:0] : partial_c[WIDTH-1:0];
    quot_c_o  = {quo_q[WIDTH-2:0], ge_c};
    done_c_o  = run_q && (cnt_q == LAST);
  end

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
    end else if (run_q) begin
      if (abort_i || done_c_o) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        quo_d = quot_c_o;
        rem_d = rem_c_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; results commit only on completion.
// Define MULDIV_MADD_EN to decode MADD/MADDU/MSUB/MSUBU and build the accumulate adder.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned DW      = 2 * WIDTH;
  localparam int unsigned MAX_CYC = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             mul_signed_c, div_signed_c, in_signed_c, div_start_c, div_done_c;
  logic [DW-1:0]    ext_a_c, ext_b_c, prod_c, mul_res_c;
  logic [WIDTH-1:0] dvd_mag_c, dsr_mag_c, quot_c, rem_c, div_hi_c, div_lo_c;

  // Product from latched operands, sign- or zero-extended to the full 2*WIDTH.
  always_comb begin
    mul_signed_c = (op_q == OP_MULT);
`ifdef MULDIV_MADD_EN
    mul_signed_c = mul_signed_c || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    ext_a_c = {{WIDTH{mul_signed_c & a_q[WIDTH-1]}}, a_q};
    ext_b_c = {{WIDTH{mul_signed_c & b_q[WIDTH-1]}}, b_q};
    prod_c  = ext_a_c * ext_b_c;
`ifdef MULDIV_MADD_EN
    case (op_q)
      OP_MADD, OP_MADDU: mul_res_c = {hi_q, lo_q} + prod_c;
      OP_MSUB, OP_MSUBU: mul_res_c = {hi_q, lo_q} - prod_c;
      default:           mul_res_c = prod_c;
    endcase
`else
    mul_res_c = prod_c;
`endif
  end

  // Divider runs on magnitudes taken straight from the issue operands.
  always_comb begin
    in_signed_c = (bus.op == OP_DIV);
    dvd_mag_c   = (in_signed_c && bus.A[WIDTH-1]) ? (WIDTH'(0) - bus.A) : bus.A;
    dsr_mag_c   = (in_signed_c && bus.B[WIDTH-1]) ? (WIDTH'(0) - bus.B) : bus.B;
  end

  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start_c),
    .abort_i    (bus.flush),
    .dividend_i (dvd_mag_c),
    .divisor_i  (dsr_mag_c),
    .done_c_o   (div_done_c),
    .quot_c_o   (quot_c),
    .rem_c_o    (rem_c)
  );

  // Sign fix-up; divide-by-zero and most-negative/-1 get their architected results.
  always_comb begin
    div_signed_c = (op_q == OP_DIV);
    div_lo_c = (div_signed_c && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (WIDTH'(0) - quot_c) : quot_c;
    div_hi_c = (div_signed_c && a_q[WIDTH-1]) ? (WIDTH'(0) - rem_c) : rem_c;
    if (b_q == '0) begin
      div_lo_c = '1;
      div_hi_c = a_q;
    end else if (div_signed_c && (a_q == MOST_NEG) && (b_q == '1)) begin
      div_lo_c = MOST_NEG;
      div_hi_c = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    div_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
            state_d     = is_mul_op(bus.op) ? ST_MUL : ST_DIV;
            div_start_c = is_div_op(bus.op);
            cnt_d       = '0;
            op_d        = bus.op;
            a_d         = bus.A;
            b_d         = bus.B;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.A;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MUL_LAST) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = mul_res_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (div_done_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = div_hi_c;
          lo_d    = div_lo_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // done is registered, so it is raised on entry to the final busy cycle.
    busy_d = (state_d != ST_IDLE);
    done_d = ((state_d == ST_MUL) && (cnt_d == MUL_LAST)) ||
             ((state_d == ST_DIV) && (cnt_d == DIV_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random issue against an op-level model.
module tb_muldiv_unit;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_CYC = 5;
  localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MADD = 4'd8, MADDU = 4'd9, MSUB = 4'd10, MSUBU = 4'd11;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MUL_CYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model: remaining busy cycles plus the result that will land at commit.
  int            m_rem;
  logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
  logic [3:0]    p_op;
  logic [2*W-1:0] p_prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (op == MULT || op == MADD || op == MSUB) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic ref_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_op = NOP; p_prod = '0;
  endtask

  task automatic model_commit();
    case (p_op)
      MULT, MULTU: {m_hi, m_lo} = p_prod;
      MADD, MADDU: {m_hi, m_lo} = {m_hi, m_lo} + p_prod;
      MSUB, MSUBU: {m_hi, m_lo} = {m_hi, m_lo} - p_prod;
      default: begin m_hi = p_hi; m_lo = p_lo; end
    endcase
  endtask

  // Advance the model across one rising edge given the inputs presented to it.
  task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic f);
    if (m_rem > 0) begin
      if (f) m_rem = 0;
      else begin
        if (m_rem == 1) model_commit();
        m_rem--;
      end
    end else if (s && !f) begin
      case (op)
        MULT, MULTU: begin p_op = op; p_prod = ref_mul(op, a, b); m_rem = MUL_CYC; end
`ifdef MULDIV_MADD_EN
        MADD, MADDU, MSUB, MSUBU: begin p_op = op; p_prod = ref_mul(op, a, b); m_rem = MUL_CYC; end
`endif
        DIV, DIVU: begin p_op = op; ref_div(op, a, b, p_lo, p_hi); m_rem = W; end
        MTHI: m_hi = a;
        MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic s, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic f);
    bus.start = s; bus.op = op; bus.A = a; bus.B = b; bus.flush = f;
    @(posedge clk);
    model_edge(s, op, a, b, f);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int done_at, output int ndone);
    cyc(1'b1, op, a, b, 1'b0);
    nbusy = 0; ndone = 0; done_at = -1;
    for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
      if (bus.done === 1'b1) begin ndone++; done_at = i; end
      nbusy++;
      cyc(1'b0, NOP, $urandom, $urandom, 1'b0);
    end
    if (bus.busy === 1'b1) chk("op_timeout", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(bus.busy), 64'(m_rem != 0));
      chk("done", 64'(bus.done), 64'(m_rem == 1));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, da, nd;
    logic s, f;
    logic [3:0] op;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = NOP; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, nb, da, nd);
    chk("mult_busy_cycles", 64'(nb), 64'(MUL_CYC));
    chk("mult_done_pos", 64'(da), 64'(MUL_CYC - 1));
    chk("mult_done_cnt", 64'(nd), 64'd1);
    chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_mult", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(DIV, 32'hFFFF_FFF9, 32'd2, nb, da, nd);
    chk("div_busy_cycles", 64'(nb), 64'(W));
    chk("div_done_pos", 64'(da), 64'(W - 1));
    chk("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_div", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(DIVU, 32'd7, 32'd0, nb, da, nd);
    chk("divz_busy_cycles", 64'(nb), 64'(W));
    chk("divz_hilo", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, da, nd);
    chk("divovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    chk("model_divovf", {m_hi, m_lo}, 64'h0000_0000_8000_0000);

    // MTHI lands at the next edge; a held start during MULTU must not re-issue.
    cyc(1'b1, MTHI, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    cyc(1'b1, MULTU, 32'h0001_0000, 32'h0001_0001, 1'b0);
    nb = 0; nd = 0;
    for (int i = 0; i < 100 && m_rem != 0; i++) begin
      nb++;
      if (bus.done === 1'b1) nd++;
      cyc(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0);
    end
    bus.start = 1'b0;
    chk("held_busy_cycles", 64'(nb), 64'(MUL_CYC));
    chk("held_done_cnt", 64'(nd), 64'd1);
    chk("held_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0001_0000);

    // Flush in the 10th busy cycle of a DIVU.
    cyc(1'b1, MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
    cyc(1'b1, MTLO, 32'h0F0F_0F0F, 32'd0, 1'b0);
    cyc(1'b1, DIVU, 32'd1000, 32'd3, 1'b0);
    nd = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.done === 1'b1) nd++;
      cyc(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    end
    chk("flush_prebusy", 64'(bus.busy), 64'd1);
    cyc(1'b0, NOP, 32'd0, 32'd0, 1'b1);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done_seen", 64'(nd), 64'd0);
    cyc(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    chk("flush_no_done", 64'(bus.done), 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'hAAAA_5555_0F0F_0F0F);

    cyc(1'b1, MULT, 32'd5, 32'd5, 1'b1);
    chk("start_flush_busy", 64'(bus.busy), 64'd0);
    cyc(1'b0, NOP, 32'd0, 32'd0, 1'b1);
    chk("idle_flush_hilo", {bus.hi, bus.lo}, 64'hAAAA_5555_0F0F_0F0F);

    // Asynchronous reset mid-multiply.
    cyc(1'b1, MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    cyc(1'b1, MULT, 32'd9, 32'd9, 1'b0);
    cyc(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(1'b1, MTHI, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, MTLO, 32'd10, 32'd0, 1'b0);
    run_op(MADDU, 32'd3, 32'd4, nb, da, nd);
`ifdef MULDIV_MADD_EN
    chk("maddu_lo", 64'(bus.lo), 64'd22);
    chk("maddu_busy_cycles", 64'(nb), 64'(MUL_CYC));
`else
    chk("maddu_lo", 64'(bus.lo), 64'd10);
    chk("maddu_busy_cycles", 64'(nb), 64'd0);
`endif

    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 40) == 0);
      op = 4'($urandom_range(0, 15));
      cyc(s, op, pick(), pick(), f);
    end
    for (int i = 0; i < 100 && m_rem != 0; i++) cyc(1'b0, NOP, 32'd0, 32'd0, 1'b0);
    chk("drain_busy", 64'(bus.busy), 64'd0);
    repeat (2) cyc(1'b0, NOP, 32'd0, 32'd0, 1'b0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
